// File: rtl/csr_bus_pkg.sv
// -----------------------------------------------------------------------------
// csr_bus_pkg
// Shared definitions for the CSR bus initiator and the CSR responder blocks:
// FSM state encoding, default bus widths, the default transfer timeout and the
// read-data value returned when a transfer fails.
// -----------------------------------------------------------------------------
package csr_bus_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    RD_REQ  = 3'd2,
    RD_WAIT = 3'd3,
    RSP     = 3'd4
  } csr_state_e;

  localparam int CSR_ADDR_W      = 8;
  localparam int CSR_DATA_W      = 32;
  localparam int DEFAULT_TIMEOUT = 256;

  // Outstanding-cycle counter width and failed-transfer tally width.
  localparam int TMO_CNT_W   = 16;
  localparam int TMO_TALLY_W = 8;

  localparam logic [CSR_DATA_W-1:0] ERR_READDATA = '0;

endpackage

// File: rtl/csr_bus_initiator.sv
// -----------------------------------------------------------------------------
// csr_bus_initiator
// Avalon-MM master issuing single CSR reads/writes. One command is accepted on
// the cmd_* valid/ready port, driven onto avm_*, and exactly one response is
// returned on rsp_* (rsp_error=1 if the transfer stays outstanding too long).
//
// Ports
//   clock_sink_clk, reset_sink_reset  clock, async active-high reset
//   cmd_valid/ready/write/address/writedata   command port (ready registered)
//   rsp_valid/readdata/error          response (valid is a 1-cycle strobe,
//                                      readdata/error hold until next response)
//   avm_read/write/address/writedata/readdata/waitrequest/readdatavalid
//                                      Avalon-MM master port
//   timeout_count                     saturating tally of timed-out transfers
//   busy                              FSM not in IDLE
// All outputs are registered.
// -----------------------------------------------------------------------------
module csr_bus_initiator
  import csr_bus_pkg::*;
#(
  parameter int ADDR_W            = CSR_ADDR_W,
  parameter int DATA_W            = CSR_DATA_W,
  parameter int USE_READDATAVALID = 0,
  parameter int READ_LATENCY      = 0,
  parameter int TIMEOUT_CYCLES    = DEFAULT_TIMEOUT
) (
  input  logic              clock_sink_clk,
  input  logic              reset_sink_reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_address,
  input  logic [DATA_W-1:0] cmd_writedata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_readdata,
  output logic              rsp_error,
  output logic              avm_read,
  output logic              avm_write,
  output logic [ADDR_W-1:0] avm_address,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_waitrequest,
  input  logic              avm_readdatavalid,
  output logic [7:0]        timeout_count,
  output logic              busy
);

  localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMO_CNT_W-1:0] LAT_LAST = TMO_CNT_W'(READ_LATENCY);
  // Zero-latency fixed reads complete in the acceptance cycle itself.
  localparam bit RD_DIRECT = (USE_READDATAVALID == 0) && (READ_LATENCY == 0);

  csr_state_e r_state, w_state_nxt;

  logic                   r_cmd_ready,    w_cmd_ready_nxt;
  logic                   r_avm_read,     w_avm_read_nxt;
  logic                   r_avm_write,    w_avm_write_nxt;
  logic [ADDR_W-1:0]      r_avm_address,  w_avm_address_nxt;
  logic [DATA_W-1:0]      r_avm_wdata,    w_avm_wdata_nxt;
  logic                   r_rsp_valid,    w_rsp_valid_nxt;
  logic [DATA_W-1:0]      r_rsp_rdata,    w_rsp_rdata_nxt;
  logic                   r_rsp_error,    w_rsp_error_nxt;
  logic [TMO_CNT_W-1:0]   r_tmo_cnt,      w_tmo_cnt_nxt;
  logic [TMO_CNT_W-1:0]   r_lat_cnt,      w_lat_cnt_nxt;
  logic [TMO_TALLY_W-1:0] r_tmo_tally,    w_tmo_tally_nxt;
  logic                   r_busy,         w_busy_nxt;

  logic              w_outstanding;
  logic              w_complete;
  logic [DATA_W-1:0] w_cap_data;

  assign w_outstanding = (r_state == WR_REQ) || (r_state == RD_REQ) ||
                         (r_state == RD_WAIT);

  always_ff @(posedge clock_sink_clk or posedge reset_sink_reset) begin
    if (reset_sink_reset) begin
      r_state       <= IDLE;
      r_cmd_ready   <= 1'b0;
      r_avm_read    <= 1'b0;
      r_avm_write   <= 1'b0;
      r_avm_address <= '0;
      r_avm_wdata   <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_error   <= 1'b0;
      r_tmo_cnt     <= '0;
      r_lat_cnt     <= '0;
      r_tmo_tally   <= '0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cmd_ready   <= w_cmd_ready_nxt;
      r_avm_read    <= w_avm_read_nxt;
      r_avm_write   <= w_avm_write_nxt;
      r_avm_address <= w_avm_address_nxt;
      r_avm_wdata   <= w_avm_wdata_nxt;
      r_rsp_valid   <= w_rsp_valid_nxt;
      r_rsp_rdata   <= w_rsp_rdata_nxt;
      r_rsp_error   <= w_rsp_error_nxt;
      r_tmo_cnt     <= w_tmo_cnt_nxt;
      r_lat_cnt     <= w_lat_cnt_nxt;
      r_tmo_tally   <= w_tmo_tally_nxt;
      r_busy        <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_avm_read_nxt    = r_avm_read;
    w_avm_write_nxt   = r_avm_write;
    w_avm_address_nxt = r_avm_address;
    w_avm_wdata_nxt   = r_avm_wdata;
    w_rsp_valid_nxt   = 1'b0;
    w_rsp_rdata_nxt   = r_rsp_rdata;
    w_rsp_error_nxt   = r_rsp_error;
    w_tmo_cnt_nxt     = r_tmo_cnt;
    w_lat_cnt_nxt     = r_lat_cnt;
    w_tmo_tally_nxt   = r_tmo_tally;
    w_complete        = 1'b0;
    w_cap_data        = '0;

    if (w_outstanding) w_tmo_cnt_nxt = r_tmo_cnt + 1'b1;

    case (r_state)
      IDLE: begin
        if (cmd_valid && r_cmd_ready) begin
          w_avm_address_nxt = cmd_address;
          w_avm_wdata_nxt   = cmd_writedata;
          w_tmo_cnt_nxt     = '0;
          if (cmd_write) begin
            w_avm_write_nxt = 1'b1;
            w_state_nxt     = WR_REQ;
          end else begin
            w_avm_read_nxt  = 1'b1;
            w_state_nxt     = RD_REQ;
          end
        end
      end
      WR_REQ: begin
        if (!avm_waitrequest) w_complete = 1'b1;
      end
      RD_REQ: begin
        if (!avm_waitrequest) begin
          if (RD_DIRECT) begin
            w_complete = 1'b1;
            w_cap_data = avm_readdata;
          end else begin
            // Read accepted: the data phase is the first cycle after acceptance.
            w_avm_read_nxt = 1'b0;
            w_lat_cnt_nxt  = TMO_CNT_W'(1);
            w_state_nxt    = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if ((USE_READDATAVALID != 0) ? avm_readdatavalid : (r_lat_cnt == LAT_LAST)) begin
          w_complete = 1'b1;
          w_cap_data = avm_readdata;
        end else begin
          w_lat_cnt_nxt = r_lat_cnt + 1'b1;
        end
      end
      RSP:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase

    // Completion takes priority over a timeout landing in the same cycle.
    if (w_complete) begin
      w_avm_read_nxt  = 1'b0;
      w_avm_write_nxt = 1'b0;
      w_rsp_valid_nxt = 1'b1;
      w_rsp_error_nxt = 1'b0;
      w_rsp_rdata_nxt = w_cap_data;
      w_state_nxt     = RSP;
    end else if (w_outstanding && (r_tmo_cnt == TMO_LAST)) begin
      w_avm_read_nxt  = 1'b0;
      w_avm_write_nxt = 1'b0;
      w_rsp_valid_nxt = 1'b1;
      w_rsp_error_nxt = 1'b1;
      w_rsp_rdata_nxt = DATA_W'(ERR_READDATA);
      w_state_nxt     = RSP;
      if (r_tmo_tally != '1) w_tmo_tally_nxt = r_tmo_tally + 1'b1;
    end

    w_cmd_ready_nxt = (w_state_nxt == IDLE);
    w_busy_nxt      = (w_state_nxt != IDLE);
  end

  assign cmd_ready     = r_cmd_ready;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_readdata  = r_rsp_rdata;
  assign rsp_error     = r_rsp_error;
  assign avm_read      = r_avm_read;
  assign avm_write     = r_avm_write;
  assign avm_address   = r_avm_address;
  assign avm_writedata = r_avm_wdata;
  assign timeout_count = r_tmo_tally;
  assign busy          = r_busy;

endmodule
